// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write queue.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } regwr_entry_t;

    typedef logic [$clog2(DEPTH):0] count_t;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/regwr_fifo.sv
// Generic DEPTH-entry in-order queue with pointer/count tracking and
// per-slot valid bits so the owner can scan pending entries.
module regwr_fifo #(
    parameter  int W     = 34,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic                      ready,
    output logic [CNT_W-1:0]          count,
    output logic [DEPTH-1:0]          valid,
    output logic [PTR_W-1:0]          rd_ptr,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0][W-1:0]   entries
);
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [DEPTH-1:0][W-1:0] mem_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;
    logic [DEPTH-1:0]        valid_s;

    assign ready     = (count_r != CNT_W'(DEPTH));
    assign push_ok_s = push && ready;
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_ptr    = rd_ptr_r;
    assign head      = mem_r[rd_ptr_r];
    assign entries   = mem_r;
    assign valid     = valid_s;

    // Pointer and occupancy state; full/empty come from the count, never pointer equality.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // A slot is pending when its distance from the read pointer is below the count.
    always_comb begin
        valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off_v;
            off_v      = PTR_W'(i) - rd_ptr_r;
            valid_s[i] = ({1'b0, off_v} < count_r);
        end
    end
endmodule

// File: rtl/regfile_write_queue.sv
// Write queue in front of the register storage with a youngest-match bypass.
// Optional build macro: REGFILE_ZERO_DROP_EN (register 0 writes are discarded).
module regfile_write_queue #(
    parameter  int DATA_W = regfile_pkg::DATA_W,
    parameter  int ADDR_W = regfile_pkg::ADDR_W,
    parameter  int DEPTH  = regfile_pkg::DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    output logic [CNT_W-1:0]  count
);
    import regfile_pkg::*;

    localparam int W     = ADDR_W + DATA_W;
    localparam int PTR_W = $clog2(DEPTH);

    logic                    drop_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    ready_s;
    logic [CNT_W-1:0]        count_s;
    logic [DEPTH-1:0]        valid_s;
    logic [PTR_W-1:0]        rd_ptr_s;
    logic [W-1:0]            head_s;
    logic [DEPTH-1:0][W-1:0] entries_s;

`ifdef REGFILE_ZERO_DROP_EN
    assign drop_s = (req_addr == {ADDR_W{1'b0}});
`else
    assign drop_s = 1'b0;
`endif

    // Dropped requests still complete the handshake, they just never reach the queue.
    assign push_s    = req_valid && ready_s && !drop_s;
    assign pop_s     = wr && wr_ready;
    assign req_ready = ready_s;
    assign count     = count_s;
    assign wr        = (count_s != {CNT_W{1'b0}});

    regwr_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({req_addr, req_data}),
        .pop       (pop_s),
        .ready     (ready_s),
        .count     (count_s),
        .valid     (valid_s),
        .rd_ptr    (rd_ptr_s),
        .head      (head_s),
        .entries   (entries_s)
    );

    // Head entry is forced to zero while empty so outputs are defined out of reset.
    always_comb begin
        if (wr) begin
            wr_addr = head_s[W-1:DATA_W];
            wr_data = head_s[DATA_W-1:0];
        end else begin
            wr_addr = {ADDR_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx_v;
            idx_v = rd_ptr_s + PTR_W'(k);
            if (valid_s[idx_v] && (entries_s[idx_v][W-1:DATA_W] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = entries_s[idx_v][DATA_W-1:0];
            end else begin
                lookup_hit  = lookup_hit;
                lookup_data = lookup_data;
            end
        end
`ifdef REGFILE_ZERO_DROP_EN
        if (lookup_addr == {ADDR_W{1'b0}}) begin
            lookup_hit  = 1'b0;
            lookup_data = {DATA_W{1'b0}};
        end else begin
            lookup_hit  = lookup_hit;
            lookup_data = lookup_data;
        end
`endif
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue (default parameters).
module tb_regfile_write_queue;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_addr;
    logic [31:0] req_data;
    logic        wr;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [1:0]  lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic [2:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    regfile_write_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wr          (wr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] full_addr(input int i);
`ifdef REGFILE_ZERO_DROP_EN
        return (i == 0) ? 2'd3 : 2'(i);
`else
        return 2'(i);
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 2'd0; req_data = 32'd0;
        wr_ready = 1'b0; lookup_addr = 2'd0;
        step(); step();
        total_cnt++;
        if ({wr, wr_addr, wr_data, count, lookup_hit, lookup_data, req_ready} !==
            {1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b1}) begin
            $display("FAIL reset_state: got wr=%b addr=%0d data=%h cnt=%0d hit=%b ld=%h rdy=%b, want 0/0/0/0/0/0/1",
                     wr, wr_addr, wr_data, count, lookup_hit, lookup_data, req_ready);
        end else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_addr = 2'd1; req_data = 32'hDEADBEEF; wr_ready = 1'b0;
        total_cnt++;
        if ({wr, count} !== {1'b0, 3'd0}) begin
            $display("FAIL single_no_comb_path: got wr=%b cnt=%0d, want 0/0", wr, count);
        end else pass_cnt++;
        step();
        req_valid = 1'b0;
        total_cnt++;
        if ({wr, wr_addr, wr_data, count} !== {1'b1, 2'd1, 32'hDEADBEEF, 3'd1}) begin
            $display("FAIL single_head: got wr=%b addr=%0d data=%h cnt=%0d, want 1/1/deadbeef/1",
                     wr, wr_addr, wr_data, count);
        end else pass_cnt++;
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        total_cnt++;
        if ({wr, count} !== {1'b0, 3'd0}) begin
            $display("FAIL single_drain: got wr=%b cnt=%0d, want 0/0", wr, count);
        end else pass_cnt++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = full_addr(i); req_data = 32'h10 + 32'(i);
            step();
        end
        req_addr = 2'd3; req_data = 32'h99;
        total_cnt++;
        if ({count, req_ready} !== {3'd4, 1'b0}) begin
            $display("FAIL full_state: got cnt=%0d rdy=%b, want 4/0", count, req_ready);
        end else pass_cnt++;
        step();
        req_valid = 1'b0;
        total_cnt++;
        if (count !== 3'd4) begin
            $display("FAIL full_reject: got cnt=%0d, want 4", count);
        end else pass_cnt++;
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({wr, wr_addr, wr_data} !== {1'b1, full_addr(i), 32'h10 + 32'(i)}) begin
                $display("FAIL full_drain_%0d: got wr=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, wr, wr_addr, wr_data, full_addr(i), 32'h10 + 32'(i));
            end else pass_cnt++;
            step();
        end
        wr_ready = 1'b0;
        total_cnt++;
        if ({wr, count} !== {1'b0, 3'd0}) begin
            $display("FAIL full_empty: got wr=%b cnt=%0d, want 0/0", wr, count);
        end else pass_cnt++;
    endtask

    task automatic test_bypass();
        lookup_addr = 2'd2;
        req_valid = 1'b1; req_addr = 2'd2; req_data = 32'hAAAA;
        step();
        req_data = 32'hBBBB;
        step();
        req_valid = 1'b0;
        total_cnt++;
        if ({lookup_hit, lookup_data, count} !== {1'b1, 32'hBBBB, 3'd2}) begin
            $display("FAIL bypass_youngest: got hit=%b data=%h cnt=%0d, want 1/bbbb/2",
                     lookup_hit, lookup_data, count);
        end else pass_cnt++;
        lookup_addr = 2'd1;
        #1;
        total_cnt++;
        if ({lookup_hit, lookup_data} !== {1'b0, 32'd0}) begin
            $display("FAIL bypass_miss: got hit=%b data=%h, want 0/0", lookup_hit, lookup_data);
        end else pass_cnt++;
        lookup_addr = 2'd2;
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        total_cnt++;
        if ({lookup_hit, lookup_data, count} !== {1'b1, 32'hBBBB, 3'd1}) begin
            $display("FAIL bypass_after_pop1: got hit=%b data=%h cnt=%0d, want 1/bbbb/1",
                     lookup_hit, lookup_data, count);
        end else pass_cnt++;
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        total_cnt++;
        if ({lookup_hit, lookup_data, count} !== {1'b0, 32'd0, 3'd0}) begin
            $display("FAIL bypass_after_pop2: got hit=%b data=%h cnt=%0d, want 0/0/0",
                     lookup_hit, lookup_data, count);
        end else pass_cnt++;
    endtask

    // Entry j carries addr (j%3)+1 and data 0x100+j; head must follow that sequence.
    task automatic test_back_to_back();
        for (int j = 0; j < 2; j++) begin
            req_valid = 1'b1; req_addr = 2'((j % 3) + 1); req_data = 32'h100 + 32'(j);
            step();
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 2'(((i + 2) % 3) + 1); req_data = 32'h102 + 32'(i);
            total_cnt++;
            if ({wr, wr_addr, wr_data, count, req_ready} !==
                {1'b1, 2'((i % 3) + 1), 32'h100 + 32'(i), 3'd2, 1'b1}) begin
                $display("FAIL b2b_%0d: got wr=%b addr=%0d data=%h cnt=%0d rdy=%b, want 1/%0d/%h/2/1",
                         i, wr, wr_addr, wr_data, count, req_ready, (i % 3) + 1, 32'h100 + 32'(i));
            end else pass_cnt++;
            step();
        end
        req_valid = 1'b0;
        for (int i = 8; i < 10; i++) begin
            total_cnt++;
            if ({wr, wr_addr, wr_data} !== {1'b1, 2'((i % 3) + 1), 32'h100 + 32'(i)}) begin
                $display("FAIL b2b_tail_%0d: got wr=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, wr, wr_addr, wr_data, (i % 3) + 1, 32'h100 + 32'(i));
            end else pass_cnt++;
            step();
        end
        wr_ready = 1'b0;
        total_cnt++;
        if ({wr, count} !== {1'b0, 3'd0}) begin
            $display("FAIL b2b_empty: got wr=%b cnt=%0d, want 0/0", wr, count);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        lookup_addr = 2'd3;
        for (int j = 1; j <= 3; j++) begin
            req_valid = 1'b1; req_addr = 2'(j); req_data = 32'h200 + 32'(j);
            step();
        end
        req_valid = 1'b0;
        total_cnt++;
        if ({wr, count, lookup_hit, lookup_data} !== {1'b1, 3'd3, 1'b1, 32'h203}) begin
            $display("FAIL mid_pre: got wr=%b cnt=%0d hit=%b data=%h, want 1/3/1/203",
                     wr, count, lookup_hit, lookup_data);
        end else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({wr, count, lookup_hit, wr_addr, wr_data} !== {1'b0, 3'd0, 1'b0, 2'd0, 32'd0}) begin
            $display("FAIL mid_async: got wr=%b cnt=%0d hit=%b addr=%0d data=%h, want all 0",
                     wr, count, lookup_hit, wr_addr, wr_data);
        end else pass_cnt++;
        step();
        #2 rst_n = 1'b1;
        step();
        total_cnt++;
        if ({req_ready, count, wr} !== {1'b1, 3'd0, 1'b0}) begin
            $display("FAIL mid_release: got rdy=%b cnt=%0d wr=%b, want 1/0/0", req_ready, count, wr);
        end else pass_cnt++;
    endtask

    task automatic test_zero_addr();
        lookup_addr = 2'd0;
        req_valid = 1'b1; req_addr = 2'd0; req_data = 32'h1234;
        total_cnt++;
        if (req_ready !== 1'b1) begin
            $display("FAIL zero_ready: got rdy=%b, want 1", req_ready);
        end else pass_cnt++;
        step();
        req_valid = 1'b0;
`ifdef REGFILE_ZERO_DROP_EN
        total_cnt++;
        if ({count, wr, lookup_hit} !== {3'd0, 1'b0, 1'b0}) begin
            $display("FAIL zero_drop: got cnt=%0d wr=%b hit=%b, want 0/0/0", count, wr, lookup_hit);
        end else pass_cnt++;
`else
        total_cnt++;
        if ({count, wr, wr_addr, lookup_hit, lookup_data} !== {3'd1, 1'b1, 2'd0, 1'b1, 32'h1234}) begin
            $display("FAIL zero_plain: got cnt=%0d wr=%b addr=%0d hit=%b data=%h, want 1/1/0/1/1234",
                     count, wr, wr_addr, lookup_hit, lookup_data);
        end else pass_cnt++;
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        total_cnt++;
        if ({count, wr, lookup_hit} !== {3'd0, 1'b0, 1'b0}) begin
            $display("FAIL zero_plain_drain: got cnt=%0d wr=%b hit=%b, want 0/0/0", count, wr, lookup_hit);
        end else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        test_zero_addr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
